tt_sweep_checker: RTL and testbench
===================================

Name: tt_sweep_checker

Overview:
- Sequential stimulus/response stage wrapped around a combinational boolean block (e.g. an N-input, 1-output function such as F=(A^B)&(~C|D)).
- Upstream role: drives every input combination 0..2^N_IN-1 onto the block's inputs, holding each one for a programmable settle time.
- Downstream role: samples the block's output F, builds the full truth table, counts ones, and compares each entry against an expected mask.
- Replaces hand-written exhaustive `#5` stimulus lists with one reusable, self-checking sweep.

Parameters:
- N_IN, 5, number of inputs of the function under test; vec_o[N_IN-1] drives the first-listed input (A), vec_o[0] the last.
- SETTLE_CYC, 1, extra cycles each vector is held before F is sampled; legal range 0..15.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin sweep; honoured only in IDLE or DONE.
- expected_i  in  2^N_IN  expected truth table; bit v = expected F for input vector v.
- f_i  in  1  output F of the block under test.
- vec_o  out  N_IN  input vector driven to the block under test.
- busy  out  1  sweep in progress.
- done  out  1  sweep complete; held until next start or reset.
- tt_o  out  2^N_IN  captured truth table; bit v = sampled F for vector v.
- ones_cnt  out  N_IN+1  number of vectors where F=1.
- mismatch_cnt  out  N_IN+1  number of vectors where F differs from the expected bit.
- first_fail_idx  out  N_IN  lowest vector index that mismatched.
- first_fail_valid  out  1  first_fail_idx is meaningful.
- pass  out  1  done && mismatch_cnt==0.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs, the settle counter and the internal expected register are cleared to 0. Outputs stay at these values while rst_n=0. Reset mid-sweep abandons the sweep; no partial results are kept.
- States: IDLE, SETTLE, SAMPLE, DONE.
- Start (IDLE or DONE, start=1 at edge 0). On that edge:
  - register expected_i internally; later changes on expected_i have no effect.
  - clear tt_o, ones_cnt, mismatch_cnt, first_fail_idx, first_fail_valid, done.
  - set vec_o=0, busy=1, settle counter=SETTLE_CYC.
  - go to SETTLE, or directly to SAMPLE if SETTLE_CYC=0.
- SETTLE: counter decrements each cycle; when it reaches 0, go to SAMPLE. vec_o is held constant.
- SAMPLE (one cycle). At the edge leaving SAMPLE:
  - tt_o[vec_o] <= f_i.
  - ones_cnt += f_i.
  - if f_i != exp[vec_o]: mismatch_cnt += 1; if first_fail_valid=0, set first_fail_idx=vec_o and first_fail_valid=1.
  - if vec_o == 2^N_IN-1: go to DONE, set busy=0, done=1. vec_o stays at its last value; no wrap to 0.
  - otherwise: vec_o += 1, reload the settle counter, go to SETTLE (or SAMPLE again if SETTLE_CYC=0).
- Timing: each vector is driven for SETTLE_CYC+1 cycles. Vector v is sampled at edge (v+1)*(SETTLE_CYC+1). done rises after edge 2^N_IN*(SETTLE_CYC+1).
- start while busy: ignored; no restart, no effect on counters.
- start in DONE: behaves as from IDLE. done drops and results clear on that same edge.
- Counter widths: N_IN+1 bits, so the all-ones and all-mismatch case (value 2^N_IN) is representable without overflow.
- pass: combinational from done and mismatch_cnt; 0 whenever done=0.

Test Plan:
1. N_IN=4, SETTLE_CYC=1, DUT F=(A^B)&(~C|D), expected_i=16'h0BB0, start pulse -> done rises 32 cycles after start; tt_o=16'h0BB0, ones_cnt=6, mismatch_cnt=0, first_fail_valid=0, pass=1.
2. Same DUT, expected_i=16'h0BB1 -> mismatch_cnt=1, first_fail_idx=0, first_fail_valid=1, pass=0, tt_o=16'h0BB0.
3. N_IN=4, f_i tied 1, expected_i=0 -> ones_cnt=16, mismatch_cnt=16 (no overflow), first_fail_idx=0, tt_o=16'hFFFF.
4. Case 1 setup with start re-pulsed at vector 5 -> ignored, done still at cycle 32. Then rst_n=0 at vector 7 -> vec_o=0, busy=0, tt_o=0 immediately (asynchronous). A new start after reset gives the full case-1 result.
5. SETTLE_CYC=0, case-1 DUT -> vec_o increments every cycle and done rises at cycle 16. Restart from DONE -> done=0 and tt_o=0 on the restart edge; result repeats identically.
6. Case 1 with expected_i switched to 16'hFFFF one cycle after start -> result identical to case 1; pass=1.

Source files
------------

// File: rtl/tt_sweep_checker.sv
// Exhaustive truth-table sweep around a combinational block: drives every input
// vector, samples F after a settle delay and compares against an expected mask.
module tt_sweep_checker #(
  parameter int N_IN       = 5,
  parameter int SETTLE_CYC = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2**N_IN-1:0]   expected_i,
  input  logic                 f_i,
  output logic [N_IN-1:0]      vec_o,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   tt_o,
  output logic [N_IN:0]        ones_cnt,
  output logic [N_IN:0]        mismatch_cnt,
  output logic [N_IN-1:0]      first_fail_idx,
  output logic                 first_fail_valid,
  output logic                 pass
);

  localparam int NV = 2**N_IN;
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  // With no settle time a freshly driven vector is sampled on the very next edge.
  localparam state_t LOAD_STATE = (SETTLE_CYC == 0) ? SAMPLE : SETTLE;

  state_t          state;
  state_t          state_next;
  logic [3:0]      settle_cnt;
  logic [NV-1:0]   exp_q;
  logic            last_vec;
  logic            f_mismatch;

  assign last_vec   = (vec_o == {N_IN{1'b1}});
  assign f_mismatch = (f_i != exp_q[vec_o]);
  assign pass       = done && (mismatch_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next = LOAD_STATE;
        end
      end
      SETTLE: begin
        // Leave when the counter is about to hit zero so the vector is held SETTLE_CYC+1 cycles.
        if (settle_cnt <= 4'd1) begin
          state_next = SAMPLE;
        end
      end
      SAMPLE: begin
        state_next = last_vec ? DONE : LOAD_STATE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt       <= '0;
      exp_q            <= '0;
      vec_o            <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      tt_o             <= '0;
      ones_cnt         <= '0;
      mismatch_cnt     <= '0;
      first_fail_idx   <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            exp_q            <= expected_i;
            tt_o             <= '0;
            ones_cnt         <= '0;
            mismatch_cnt     <= '0;
            first_fail_idx   <= '0;
            first_fail_valid <= 1'b0;
            done             <= 1'b0;
            vec_o            <= '0;
            busy             <= 1'b1;
            settle_cnt       <= SETTLE_LOAD;
          end
        end
        SETTLE: begin
          if (settle_cnt != 4'd0) begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        SAMPLE: begin
          tt_o[vec_o] <= f_i;
          ones_cnt    <= ones_cnt + {{N_IN{1'b0}}, f_i};
          if (f_mismatch) begin
            mismatch_cnt <= mismatch_cnt + (N_IN+1)'(1);
            if (!first_fail_valid) begin
              first_fail_idx   <= vec_o;
              first_fail_valid <= 1'b1;
            end
          end
          // The final vector stays on vec_o after the sweep rather than wrapping.
          if (last_vec) begin
            busy <= 1'b0;
            done <= 1'b1;
          end else begin
            vec_o      <= vec_o + N_IN'(1);
            settle_cnt <= SETTLE_LOAD;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Self-checking bench: two 4-input checkers (settle 1 and settle 0) sweeping a
// modelled boolean block, with directed cases and random truth tables/masks.
module tb_tt_sweep_checker;

  localparam int N  = 4;
  localparam int NV = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    start = 2'b00;
  logic [NV-1:0] expected [2];
  logic [NV-1:0] func [2];
  logic          f [2];
  logic [N-1:0]  vec [2];
  logic          busy [2];
  logic          done [2];
  logic [NV-1:0] tt [2];
  logic [N:0]    ones [2];
  logic [N:0]    mism [2];
  logic [N-1:0]  ffi [2];
  logic          ffv [2];
  logic          pass [2];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Block under test is modelled as a lookup of the chosen truth table.
  assign f[0] = func[0][vec[0]];
  assign f[1] = func[1][vec[1]];

  tt_sweep_checker #(.N_IN(N), .SETTLE_CYC(0)) dut_s0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .expected_i(expected[0]), .f_i(f[0]),
    .vec_o(vec[0]), .busy(busy[0]), .done(done[0]), .tt_o(tt[0]), .ones_cnt(ones[0]),
    .mismatch_cnt(mism[0]), .first_fail_idx(ffi[0]), .first_fail_valid(ffv[0]), .pass(pass[0])
  );

  tt_sweep_checker #(.N_IN(N), .SETTLE_CYC(1)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .expected_i(expected[1]), .f_i(f[1]),
    .vec_o(vec[1]), .busy(busy[1]), .done(done[1]), .tt_o(tt[1]), .ones_cnt(ones[1]),
    .mismatch_cnt(mism[1]), .first_fail_idx(ffi[1]), .first_fail_valid(ffv[1]), .pass(pass[1])
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // F = (A^B) & (~C|D) with A on the most significant vector bit.
  function automatic logic [NV-1:0] case_f();
    logic [NV-1:0] r;
    logic a, b, c, d;
    r = '0;
    for (int v = 0; v < NV; v++) begin
      a = v[3]; b = v[2]; c = v[1]; d = v[0];
      r[v] = (a ^ b) & (~c | d);
    end
    return r;
  endfunction

  task automatic model(input logic [NV-1:0] fm, input logic [NV-1:0] em,
                       output int m_ones, output int m_mism, output int m_ffi, output int m_ffv);
    m_ones = 0; m_mism = 0; m_ffi = 0; m_ffv = 0;
    for (int v = 0; v < NV; v++) begin
      if (fm[v]) m_ones++;
      if (fm[v] != em[v]) begin
        if (m_ffv == 0) begin
          m_ffi = v;
          m_ffv = 1;
        end
        m_mism++;
      end
    end
  endtask

  task automatic check_reset_state(input int d, input string tag);
    check_output({tag, "_vec"},  32'(vec[d]),  32'd0);
    check_output({tag, "_busy"}, 32'(busy[d]), 32'd0);
    check_output({tag, "_done"}, 32'(done[d]), 32'd0);
    check_output({tag, "_tt"},   32'(tt[d]),   32'd0);
    check_output({tag, "_ones"}, 32'(ones[d]), 32'd0);
    check_output({tag, "_mism"}, 32'(mism[d]), 32'd0);
    check_output({tag, "_ffv"},  32'(ffv[d]),  32'd0);
    check_output({tag, "_pass"}, 32'(pass[d]), 32'd0);
  endtask

  // One full sweep on DUT d; optional start re-pulse at a vector, expected-mask swap
  // right after start, or an asynchronous reset that abandons the sweep at a vector.
  task automatic apply_stimulus(input int d, input logic [NV-1:0] fm, input logic [NV-1:0] em,
                                input bit swap_exp, input int repulse_at, input int reset_at,
                                input string tag);
    int lat, budget, cyc;
    int m_ones, m_mism, m_ffi, m_ffv;
    lat = (d == 1) ? 2 : 1;
    budget = NV * lat;
    func[d] = fm;
    expected[d] = em;
    @(negedge clk);
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    check_output({tag, "_start_busy"}, 32'(busy[d]), 32'd1);
    check_output({tag, "_start_done"}, 32'(done[d]), 32'd0);
    check_output({tag, "_start_tt"},   32'(tt[d]),   32'd0);
    check_output({tag, "_start_mism"}, 32'(mism[d]), 32'd0);
    if (swap_exp) expected[d] = 16'hFFFF;
    cyc = 0;
    while (!done[d] && cyc <= budget + 4) begin
      check_output({tag, "_vec"}, 32'(vec[d]), 32'(cyc / lat));
      start[d] = (cyc / lat == repulse_at);
      if (reset_at >= 0 && cyc / lat == reset_at) begin
        #2 rst_n = 1'b0;
        #1 check_reset_state(d, {tag, "_async_rst"});
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      @(negedge clk);
      cyc++;
    end
    start[d] = 1'b0;
    check_output({tag, "_done_latency"}, 32'(cyc), 32'(budget));
    model(fm, (swap_exp ? em : expected[d]), m_ones, m_mism, m_ffi, m_ffv);
    check_output({tag, "_tt"},   32'(tt[d]),   32'(fm));
    check_output({tag, "_ones"}, 32'(ones[d]), 32'(m_ones));
    check_output({tag, "_mism"}, 32'(mism[d]), 32'(m_mism));
    check_output({tag, "_ffi"},  32'(ffi[d]),  32'(m_ffi));
    check_output({tag, "_ffv"},  32'(ffv[d]),  32'(m_ffv));
    check_output({tag, "_pass"}, 32'(pass[d]), 32'(m_mism == 0));
    check_output({tag, "_busy"}, 32'(busy[d]), 32'd0);
    check_output({tag, "_lastvec"}, 32'(vec[d]), 32'(NV - 1));
  endtask

  initial begin
    logic [NV-1:0] fcase, frand, erand;
    func[0] = '0; func[1] = '0;
    expected[0] = '0; expected[1] = '0;
    fcase = case_f();

    repeat (2) @(negedge clk);
    check_reset_state(0, "reset_s0");
    check_reset_state(1, "reset_s1");
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] directed cases");
    apply_stimulus(1, fcase, 16'h0BB0, 1'b0, -1, -1, "c1_match");
    apply_stimulus(1, fcase, 16'h0BB1, 1'b0, -1, -1, "c2_onefail");
    apply_stimulus(1, 16'hFFFF, 16'h0000, 1'b0, -1, -1, "c3_allones");
    apply_stimulus(1, fcase, 16'h0BB0, 1'b0, 5, -1, "c4_repulse");
    apply_stimulus(1, fcase, 16'h0BB0, 1'b0, -1, 7, "c4_reset");
    apply_stimulus(1, fcase, 16'h0BB0, 1'b0, -1, -1, "c4_after_reset");
    apply_stimulus(0, fcase, 16'h0BB0, 1'b0, -1, -1, "c5_nosettle");
    apply_stimulus(0, fcase, 16'h0BB0, 1'b0, -1, -1, "c5_restart");
    apply_stimulus(1, fcase, 16'h0BB0, 1'b1, -1, -1, "c6_expswap");

    repeat (3) @(negedge clk);
    check_output("hold_done", 32'(done[1]), 32'd1);
    check_output("hold_tt",   32'(tt[1]),   32'(fcase));

    $display("[TB] random cases");
    for (int i = 0; i < 8; i++) begin
      frand = 16'($urandom);
      erand = frand ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
      apply_stimulus(i % 2, frand, erand, 1'b0, -1, -1, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
